// File: rtl/issue_queue_scheduler.sv
// Issue queue scheduler: holds dispatched entries and a physical-register
// readiness scoreboard. Each cycle it selects the oldest entry whose sources
// are ready. Memory entries leave in program order relative to other memory
// entries.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   disp_valid / disp_ready           dispatch handshake
//   disp_rs/rt/rw, disp_uses_rs/rt/rw source/dest tags and their use flags
//   disp_is_mem, disp_payload         memory flag, opaque payload
//   wb_valid, wb_tag                  writeback wakeup broadcast
//   issue_valid / issue_ready         issue handshake
//   issue_rw, issue_uses_rw           destination of the selected entry
//   issue_payload                     payload of the selected entry
//   flush                             synchronous mispredict flush
//   count                             number of occupied entries
module issue_queue_scheduler #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [PREG_W-1:0]      disp_rs,
  input  logic [PREG_W-1:0]      disp_rt,
  input  logic [PREG_W-1:0]      disp_rw,
  input  logic                   disp_uses_rs,
  input  logic                   disp_uses_rt,
  input  logic                   disp_uses_rw,
  input  logic                   disp_is_mem,
  input  logic [PAYLOAD_W-1:0]   disp_payload,
  input  logic                   wb_valid,
  input  logic [PREG_W-1:0]      wb_tag,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [PREG_W-1:0]      issue_rw,
  output logic                   issue_uses_rw,
  output logic [PAYLOAD_W-1:0]   issue_payload,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned NTAG  = 1 << PREG_W;

  // Entry storage
  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     rs_rdy;
  logic [DEPTH-1:0]     rt_rdy;
  logic [DEPTH-1:0]     is_mem;
  logic [DEPTH-1:0]     uses_rw;
  logic [PREG_W-1:0]    rs    [DEPTH];
  logic [PREG_W-1:0]    rt    [DEPTH];
  logic [PREG_W-1:0]    rw    [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];
  // age[i][j] = 1 means entry j is older than entry i
  logic [DEPTH-1:0]     age   [DEPTH];
  // Scoreboard of ready physical registers
  logic [NTAG-1:0]      sb;

  logic [IDX_W-1:0]     free_idx;
  logic [DEPTH-1:0]     cand;
  logic [DEPTH-1:0]     older_mem;
  logic [DEPTH-1:0]     sel_oh;
  logic                 accept;
  logic                 do_issue;
  logic                 disp_rs_rdy;
  logic                 disp_rt_rdy;

  assign disp_ready = (count != CNT_W'(DEPTH));
  assign accept     = disp_valid && disp_ready;
  assign do_issue   = issue_valid && issue_ready;

  // Source readiness at dispatch, including same-cycle writeback bypass
  assign disp_rs_rdy = !disp_uses_rs || sb[disp_rs] || (wb_valid && (wb_tag == disp_rs));
  assign disp_rt_rdy = !disp_uses_rt || sb[disp_rt] || (wb_valid && (wb_tag == disp_rt));

  // Lowest-index free slot
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  // Candidate selection and oldest-candidate pick
  always_comb begin
    cand      = '0;
    older_mem = '0;
    sel_oh    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      older_mem[i] = |(age[i] & valid & is_mem);
      cand[i] = valid[i] && rs_rdy[i] && rt_rdy[i] && (!is_mem[i] || !older_mem[i]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = cand[i] && ((cand & age[i]) == '0);
    end
  end

  // Issue outputs driven from the chosen entry, zero when none
  always_comb begin
    issue_valid   = |cand;
    issue_rw      = '0;
    issue_uses_rw = 1'b0;
    issue_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        issue_rw      = rw[i];
        issue_uses_rw = uses_rw[i];
        issue_payload = payload[i];
      end
    end
  end

  // Entry, age matrix, scoreboard and occupancy state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= '0;
      rs_rdy  <= '0;
      rt_rdy  <= '0;
      is_mem  <= '0;
      uses_rw <= '0;
      count   <= '0;
      sb      <= '1;
      for (int i = 0; i < DEPTH; i++) begin
        rs[i]      <= '0;
        rt[i]      <= '0;
        rw[i]      <= '0;
        payload[i] <= '0;
        age[i]     <= '0;
      end
    end else if (flush) begin
      valid <= '0;
      count <= '0;
      sb    <= '1;
    end else begin
      // Wakeup of waiting sources
      if (wb_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid[i] && (rs[i] == wb_tag)) rs_rdy[i] <= 1'b1;
          if (valid[i] && (rt[i] == wb_tag)) rt_rdy[i] <= 1'b1;
        end
      end

      if (do_issue) valid <= valid & ~sel_oh;

      if (accept) begin
        valid[free_idx]   <= 1'b1;
        rs[free_idx]      <= disp_rs;
        rt[free_idx]      <= disp_rt;
        rw[free_idx]      <= disp_rw;
        uses_rw[free_idx] <= disp_uses_rw;
        is_mem[free_idx]  <= disp_is_mem;
        payload[free_idx] <= disp_payload;
        rs_rdy[free_idx]  <= disp_rs_rdy;
        rt_rdy[free_idx]  <= disp_rt_rdy;
        // New entry is youngest: nobody may regard its slot as older
        for (int x = 0; x < DEPTH; x++) age[x][free_idx] <= 1'b0;
        age[free_idx] <= valid;
      end

      // Scoreboard: a new producer's clear overrides a same-cycle set
      if (wb_valid) sb[wb_tag] <= 1'b1;
      if (accept && disp_uses_rw && (disp_rw != '0)) sb[disp_rw] <= 1'b0;

      case ({accept, do_issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_queue_scheduler.sv
// Directed self-checking bench for issue_queue_scheduler.
module tb_issue_queue_scheduler;

  logic        clk;
  logic        rst;
  logic        disp_valid;
  logic        disp_ready;
  logic [5:0]  disp_rs;
  logic [5:0]  disp_rt;
  logic [5:0]  disp_rw;
  logic        disp_uses_rs;
  logic        disp_uses_rt;
  logic        disp_uses_rw;
  logic        disp_is_mem;
  logic [63:0] disp_payload;
  logic        wb_valid;
  logic [5:0]  wb_tag;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_rw;
  logic        issue_uses_rw;
  logic [63:0] issue_payload;
  logic        flush;
  logic [3:0]  count;

  int checks;
  int errors;

  issue_queue_scheduler #(.DEPTH(8), .PREG_W(6), .PAYLOAD_W(64)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rs(disp_rs), .disp_rt(disp_rt), .disp_rw(disp_rw),
    .disp_uses_rs(disp_uses_rs), .disp_uses_rt(disp_uses_rt), .disp_uses_rw(disp_uses_rw),
    .disp_is_mem(disp_is_mem), .disp_payload(disp_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rw(issue_rw), .issue_uses_rw(issue_uses_rw), .issue_payload(issue_payload),
    .flush(flush), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [5:0] rs_t, input logic [5:0] rt_t, input logic [5:0] rw_t,
                      input logic urs, input logic urt, input logic urw, input logic mem,
                      input logic [63:0] pl);
    disp_valid   = 1'b1;
    disp_rs      = rs_t;
    disp_rt      = rt_t;
    disp_rw      = rw_t;
    disp_uses_rs = urs;
    disp_uses_rt = urt;
    disp_uses_rw = urw;
    disp_is_mem  = mem;
    disp_payload = pl;
  endtask

  task automatic idle();
    disp_valid   = 1'b0;
    disp_uses_rs = 1'b0;
    disp_uses_rt = 1'b0;
    disp_uses_rw = 1'b0;
    disp_is_mem  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    issue_ready = 1'b0;
    wb_valid = 1'b0;
    wb_tag = '0;
    disp_rs = '0;
    disp_rt = '0;
    disp_rw = '0;
    disp_payload = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_issue_payload", issue_payload, 64'd0);
    chk("rst_issue_rw", 64'(issue_rw), 64'd0);

    // 1: three independent ops issue in dispatch order
    disp(6'd0, 6'd0, 6'd10, 1'b0, 1'b0, 1'b1, 1'b0, 64'h11); tick();
    disp(6'd0, 6'd0, 6'd11, 1'b0, 1'b0, 1'b1, 1'b0, 64'h22); tick();
    disp(6'd0, 6'd0, 6'd12, 1'b0, 1'b0, 1'b1, 1'b0, 64'h33); tick();
    idle();
    chk("t1_count3", 64'(count), 64'd3);
    chk("t1_valid", 64'(issue_valid), 64'd1);
    chk("t1_pl_first", issue_payload, 64'h11);
    chk("t1_rw_first", 64'(issue_rw), 64'd10);
    chk("t1_uses_rw", 64'(issue_uses_rw), 64'd1);
    issue_ready = 1'b1;
    tick();
    chk("t1_pl_second", issue_payload, 64'h22);
    chk("t1_count2", 64'(count), 64'd2);
    tick();
    chk("t1_pl_third", issue_payload, 64'h33);
    chk("t1_count1", 64'(count), 64'd1);
    tick();
    chk("t1_count0", 64'(count), 64'd0);
    chk("t1_empty_valid", 64'(issue_valid), 64'd0);
    chk("t1_empty_pl", issue_payload, 64'd0);

    // 2: dependent op waits for writeback
    disp(6'd0, 6'd0, 6'd5, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA0); tick();
    chk("t2_a_visible", issue_payload, 64'hA0);
    disp(6'd5, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hB0); tick();
    idle();
    chk("t2_b_blocked", 64'(issue_valid), 64'd0);
    chk("t2_count", 64'(count), 64'd1);
    tick();
    chk("t2_b_still_blocked", 64'(issue_valid), 64'd0);
    wb_valid = 1'b1; wb_tag = 6'd5;
    tick();
    wb_valid = 1'b0;
    chk("t2_b_woken", 64'(issue_valid), 64'd1);
    chk("t2_b_pl", issue_payload, 64'hB0);
    tick();
    chk("t2_drained", 64'(count), 64'd0);

    // 3: same-cycle writeback bypass at dispatch
    disp(6'd0, 6'd0, 6'd7, 1'b0, 1'b0, 1'b1, 1'b0, 64'h70); tick();
    idle();
    chk("t3_p_visible", issue_payload, 64'h70);
    tick();
    disp(6'd7, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hC0);
    wb_valid = 1'b1; wb_tag = 6'd7;
    tick();
    idle();
    wb_valid = 1'b0;
    chk("t3_c_valid", 64'(issue_valid), 64'd1);
    chk("t3_c_pl", issue_payload, 64'hC0);
    tick();
    chk("t3_drained", 64'(count), 64'd0);

    // 4: full queue, all waiting on tag 9
    disp(6'd0, 6'd0, 6'd9, 1'b0, 1'b0, 1'b1, 1'b0, 64'h90); tick();
    for (int i = 0; i < 8; i++) begin
      disp(6'd9, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h40 + 64'(i));
      tick();
    end
    idle();
    chk("t4_full_count", 64'(count), 64'd8);
    chk("t4_full_ready", 64'(disp_ready), 64'd0);
    chk("t4_full_nosel", 64'(issue_valid), 64'd0);
    wb_valid = 1'b1; wb_tag = 6'd9;
    tick();
    wb_valid = 1'b0;
    chk("t4_oldest", issue_payload, 64'h40);
    chk("t4_still_full", 64'(disp_ready), 64'd0);
    tick();
    chk("t4_count7", 64'(count), 64'd7);
    chk("t4_ready_again", 64'(disp_ready), 64'd1);
    chk("t4_next", issue_payload, 64'h41);
    for (int i = 2; i < 8; i++) begin
      tick();
      chk("t4_order", issue_payload, 64'h40 + 64'(i));
    end
    tick();
    chk("t4_drained", 64'(count), 64'd0);

    // 5: memory ordering with a younger non-mem op bypassing
    disp(6'd0, 6'd0, 6'd3, 1'b0, 1'b0, 1'b1, 1'b0, 64'h30); tick();
    disp(6'd3, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h51); tick();
    disp(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h52); tick();
    chk("t5_m2_blocked", 64'(issue_valid), 64'd0);
    disp(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h53); tick();
    idle();
    issue_ready = 1'b0;
    chk("t5_n_pl", issue_payload, 64'h53);
    chk("t5_count3", 64'(count), 64'd3);
    tick();
    chk("t5_hold_pl", issue_payload, 64'h53);
    chk("t5_hold_count", 64'(count), 64'd3);
    issue_ready = 1'b1;
    tick();
    chk("t5_mems_wait", 64'(issue_valid), 64'd0);
    chk("t5_count2", 64'(count), 64'd2);
    wb_valid = 1'b1; wb_tag = 6'd3;
    tick();
    wb_valid = 1'b0;
    chk("t5_m1_first", issue_payload, 64'h51);
    tick();
    chk("t5_m2_second", issue_payload, 64'h52);
    tick();
    chk("t5_drained", 64'(count), 64'd0);

    // 6: flush with concurrent dispatch and issue
    issue_ready = 1'b0;
    disp(6'd0, 6'd0, 6'd20, 1'b0, 1'b0, 1'b1, 1'b0, 64'h20); tick();
    for (int i = 0; i < 4; i++) begin
      disp(6'd20, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h60 + 64'(i));
      tick();
    end
    idle();
    chk("t6_count5", 64'(count), 64'd5);
    chk("t6_pre_pl", issue_payload, 64'h20);
    flush = 1'b1;
    disp(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h99);
    issue_ready = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("t6_flush_count", 64'(count), 64'd0);
    chk("t6_flush_nosel", 64'(issue_valid), 64'd0);
    chk("t6_flush_ready", 64'(disp_ready), 64'd1);
    disp(6'd20, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h77); tick();
    idle();
    chk("t6_sb_ready", 64'(issue_valid), 64'd1);
    chk("t6_sb_pl", issue_payload, 64'h77);
    tick();
    chk("t6_drained", 64'(count), 64'd0);

    // Asynchronous reset mid-operation
    issue_ready = 1'b0;
    disp(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h88); tick();
    tick();
    idle();
    chk("ar_count2", 64'(count), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_count0", 64'(count), 64'd0);
    chk("ar_nosel", 64'(issue_valid), 64'd0);
    chk("ar_pl0", issue_payload, 64'd0);
    rst = 1'b0;
    tick();
    chk("ar_after", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
